// File: rtl/router_psum.sv
// router_psum: writes a PE's psum spad contents back to the psum GLB, optionally accumulating with stored values
module router_psum #(
    parameter int DATA_BITWIDTH      = 16,
    parameter int ADDR_BITWIDTH_GLB  = 10,
    parameter int ADDR_BITWIDTH_SPAD = 9,
    parameter int kernel_size        = 3,
    parameter int act_size           = 5,
    parameter int PSUM_SPAD_ADDR     = 0,
    parameter int PSUM_WRITE_ADDR    = 500
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_psum_ctrl,
    input  logic                          accum_en,
    output logic                          read_req_spad_psum,
    output logic [ADDR_BITWIDTH_SPAD-1:0] r_addr_spad_psum,
    input  logic [DATA_BITWIDTH-1:0]      r_data_spad_psum,
    output logic                          read_req_glb_psum,
    output logic [ADDR_BITWIDTH_GLB-1:0]  r_addr_glb_psum,
    input  logic [DATA_BITWIDTH-1:0]      r_data_glb_psum,
    output logic                          write_en_glb_psum,
    output logic [ADDR_BITWIDTH_GLB-1:0]  w_addr_glb_psum,
    output logic [DATA_BITWIDTH-1:0]      w_data_glb_psum,
    output logic                          busy,
    output logic                          done
);
    localparam int N  = (act_size - kernel_size + 1) ** 2;
    localparam int IW = N > 1 ? $clog2(N) : 1;
    typedef enum logic [2:0] {IDLE, RD_SPAD, CAP_SPAD, RD_GLB, ACCUM, WRITE, DONE} state_t;
    state_t                        state, nxt;
    logic [IW-1:0]                 idx, nxt_idx;
    logic                          accum;
    logic [DATA_BITWIDTH-1:0]      spad_val, nxt_data;
    logic [ADDR_BITWIDTH_SPAD-1:0] nxt_spad_addr;
    logic [ADDR_BITWIDTH_GLB-1:0]  nxt_glb_addr;
    // outputs are registered from the next state so they line up with the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            idx                <= '0;
            accum              <= 1'b0;
            spad_val           <= '0;
            read_req_spad_psum <= 1'b0;
            r_addr_spad_psum   <= '0;
            read_req_glb_psum  <= 1'b0;
            r_addr_glb_psum    <= '0;
            write_en_glb_psum  <= 1'b0;
            w_addr_glb_psum    <= '0;
            w_data_glb_psum    <= '0;
            busy               <= 1'b0;
            done               <= 1'b0;
        end else begin
            state <= nxt;
            idx   <= nxt_idx;
            if (state == IDLE && write_psum_ctrl) accum <= accum_en;
            if (state == CAP_SPAD) spad_val <= r_data_spad_psum;
            read_req_spad_psum <= nxt == RD_SPAD;
            if (nxt == RD_SPAD) r_addr_spad_psum <= nxt_spad_addr;
            read_req_glb_psum <= nxt == RD_GLB;
            if (nxt == RD_GLB) r_addr_glb_psum <= nxt_glb_addr;
            write_en_glb_psum <= nxt == WRITE;
            if (nxt == WRITE) begin
                w_addr_glb_psum <= nxt_glb_addr;
                w_data_glb_psum <= nxt_data;
            end
            busy <= nxt != IDLE && nxt != DONE;
            done <= nxt == DONE;
        end
    end
    always_comb begin
        nxt     = state;
        nxt_idx = idx;
        case (state)
            IDLE:     if (write_psum_ctrl) begin
                          nxt     = RD_SPAD;
                          nxt_idx = '0;
                      end
            RD_SPAD:  nxt = CAP_SPAD;
            CAP_SPAD: nxt = accum ? RD_GLB : WRITE;
            RD_GLB:   nxt = ACCUM;
            ACCUM:    nxt = WRITE;
            WRITE:    if (idx == IW'(N - 1)) nxt = DONE;
                      else begin
                          nxt     = RD_SPAD;
                          nxt_idx = idx + 1'b1;
                      end
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
    end
    // the GLB read data is valid during ACCUM, so the sum goes straight into the write-data register
    always_comb begin
        nxt_spad_addr = ADDR_BITWIDTH_SPAD'(PSUM_SPAD_ADDR) + ADDR_BITWIDTH_SPAD'(nxt_idx);
        nxt_glb_addr  = ADDR_BITWIDTH_GLB'(PSUM_WRITE_ADDR) + ADDR_BITWIDTH_GLB'(nxt_idx);
        nxt_data      = state == ACCUM ? spad_val + r_data_glb_psum : r_data_spad_psum;
    end
endmodule

// File: tb/tb_router_psum.sv
// tb_router_psum: directed bench with spad/GLB memory models for router_psum
module tb_router_psum;
    logic        clk = 1'b0;
    logic        reset, write_psum_ctrl, accum_en;
    logic        read_req_spad_psum, read_req_glb_psum, write_en_glb_psum, busy, done;
    logic [8:0]  r_addr_spad_psum;
    logic [9:0]  r_addr_glb_psum, w_addr_glb_psum;
    logic [15:0] r_data_spad_psum, r_data_glb_psum, w_data_glb_psum;
    logic        rq_s2, rq_g2, we2, busy2, done2;
    logic [8:0]  ra_s2;
    logic [9:0]  ra_g2, wa2;
    logic [15:0] wd2;
    logic [15:0] zero16 = '0;
    logic [15:0] glb [0:1023];
    logic [15:0] spad [0:511];
    int cyc = 0, t0 = 0, n_chk = 0, n_pass = 0;
    int wr_n, busy_n, busy_first, busy_last, done_cyc;
    bit done_seen;
    int wr_cyc[$], rd_cyc[$], wa_log[$];

    router_psum dut (
        .clk(clk), .reset(reset), .write_psum_ctrl(write_psum_ctrl), .accum_en(accum_en),
        .read_req_spad_psum(read_req_spad_psum), .r_addr_spad_psum(r_addr_spad_psum),
        .r_data_spad_psum(r_data_spad_psum), .read_req_glb_psum(read_req_glb_psum),
        .r_addr_glb_psum(r_addr_glb_psum), .r_data_glb_psum(r_data_glb_psum),
        .write_en_glb_psum(write_en_glb_psum), .w_addr_glb_psum(w_addr_glb_psum),
        .w_data_glb_psum(w_data_glb_psum), .busy(busy), .done(done)
    );

    router_psum #(.PSUM_WRITE_ADDR(1020)) dut_wrap (
        .clk(clk), .reset(reset), .write_psum_ctrl(write_psum_ctrl), .accum_en(accum_en),
        .read_req_spad_psum(rq_s2), .r_addr_spad_psum(ra_s2), .r_data_spad_psum(zero16),
        .read_req_glb_psum(rq_g2), .r_addr_glb_psum(ra_g2), .r_data_glb_psum(zero16),
        .write_en_glb_psum(we2), .w_addr_glb_psum(wa2), .w_data_glb_psum(wd2),
        .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (read_req_spad_psum) r_data_spad_psum <= spad[r_addr_spad_psum];
        if (read_req_glb_psum) r_data_glb_psum <= glb[r_addr_glb_psum];
        if (write_en_glb_psum) glb[w_addr_glb_psum] = w_data_glb_psum;
    end

    always @(negedge clk) begin
        if (write_en_glb_psum) begin
            wr_cyc.push_back(cyc - t0);
            wr_n++;
        end
        if (read_req_glb_psum) rd_cyc.push_back(cyc - t0);
        if (done) begin
            done_seen = 1;
            done_cyc  = cyc - t0;
        end
        if (busy) begin
            busy_n++;
            if (busy_first < 0) busy_first = cyc - t0;
            busy_last = cyc - t0;
        end
        if (we2) wa_log.push_back(int'(wa2));
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [63:0] outs();
        return 64'({read_req_spad_psum, r_addr_spad_psum, read_req_glb_psum, r_addr_glb_psum,
                    write_en_glb_psum, w_addr_glb_psum, w_data_glb_psum, busy, done});
    endfunction

    function automatic int qget(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    task automatic clear_log();
        wr_cyc.delete();
        rd_cyc.delete();
        wa_log.delete();
        wr_n = 0; busy_n = 0; busy_first = -1; busy_last = -1; done_cyc = -1; done_seen = 0;
    endtask

    task automatic start_xfer(input bit acc);
        @(negedge clk);
        clear_log();
        t0 = cyc;
        write_psum_ctrl = 1;
        accum_en = acc;
        @(negedge clk);
        write_psum_ctrl = 0;
        accum_en = !acc;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && !done_seen; i++) @(negedge clk);
        chk("done_seen", 64'(done_seen), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        reset = 0;
        write_psum_ctrl = 0;
        accum_en = 0;
        for (int i = 0; i < 1024; i++) glb[i] = '0;
        for (int i = 0; i < 512; i++) spad[i] = '0;
        clear_log();
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        reset = 1;

        for (int i = 0; i < 9; i++) spad[i] = 16'(10 + i);
        start_xfer(0);
        wait_done(100);
        chk("direct_writes", 64'(wr_n), 64'd9);
        for (int i = 0; i < 9; i++) begin
            chk("direct_wr_cycle", 64'(qget(wr_cyc, i)), 64'(3 + 3 * i));
            chk("direct_glb", 64'(glb[500 + i]), 64'(10 + i));
            chk("wrap_addr", 64'(qget(wa_log, i)), 64'((1020 + i) % 1024));
        end
        chk("direct_done_cycle", 64'(done_cyc), 64'd28);
        chk("direct_busy_first", 64'(busy_first), 64'd1);
        chk("direct_busy_last", 64'(busy_last), 64'd27);
        chk("direct_busy_cycles", 64'(busy_n), 64'd27);
        chk("wrap_count", 64'(wa_log.size()), 64'd9);

        for (int i = 0; i < 9; i++) begin
            glb[500 + i] = 16'd100;
            spad[i] = 16'(1 + i);
        end
        start_xfer(1);
        wait_done(150);
        for (int i = 0; i < 9; i++) begin
            chk("accum_glb", 64'(glb[500 + i]), 64'(101 + i));
            chk("accum_rd_cycle", 64'(qget(rd_cyc, i)), 64'(3 + 5 * i));
        end
        chk("accum_done_cycle", 64'(done_cyc), 64'd46);
        chk("accum_writes", 64'(wr_n), 64'd9);

        glb[499] = 16'hBEEF;
        glb[509] = 16'hBEEF;
        glb[500] = 16'hFFFF;
        spad[0] = 16'd2;
        for (int i = 1; i < 9; i++) begin
            glb[500 + i] = 16'h1234;
            spad[i] = '0;
        end
        start_xfer(1);
        wait_done(150);
        chk("ovf_glb500", 64'(glb[500]), 64'h0001);
        for (int i = 1; i < 9; i++) chk("ovf_others", 64'(glb[500 + i]), 64'h1234);
        chk("ovf_below", 64'(glb[499]), 64'hBEEF);
        chk("ovf_above", 64'(glb[509]), 64'hBEEF);

        for (int i = 0; i < 9; i++) begin
            spad[i] = 16'(10 + i);
            glb[500 + i] = '0;
        end
        start_xfer(0);
        while (cyc - t0 < 10) @(negedge clk);
        write_psum_ctrl = 1;
        @(negedge clk);
        write_psum_ctrl = 0;
        while (cyc - t0 < 29) @(negedge clk);
        chk("busy_start_writes", 64'(wr_n), 64'd9);
        chk("busy_start_done", 64'(done_cyc), 64'd28);
        chk("idle_after_done", 64'(busy), 64'd0);
        clear_log();
        t0 = cyc;
        write_psum_ctrl = 1;
        accum_en = 0;
        @(negedge clk);
        write_psum_ctrl = 0;
        chk("restart_rd_spad", 64'(read_req_spad_psum), 64'd1);
        chk("restart_spad_addr", 64'(r_addr_spad_psum), 64'd0);
        chk("restart_busy", 64'(busy), 64'd1);
        wait_done(100);
        chk("restart_writes", 64'(wr_n), 64'd9);

        for (int i = 0; i < 9; i++) glb[500 + i] = 16'hAAAA;
        start_xfer(0);
        while (cyc - t0 < 10) @(negedge clk);
        reset = 0;
        #1;
        chk("midreset_outputs", outs(), 64'd0);
        repeat (3) @(negedge clk);
        chk("midreset_writes", 64'(wr_n), 64'd3);
        chk("midreset_written", 64'(glb[502]), 64'd12);
        for (int i = 3; i < 9; i++) chk("midreset_untouched", 64'(glb[500 + i]), 64'hAAAA);
        reset = 1;
        start_xfer(0);
        chk("rst_restart_rd", 64'(read_req_spad_psum), 64'd1);
        chk("rst_restart_spad_addr", 64'(r_addr_spad_psum), 64'd0);
        while (cyc - t0 < 3) @(negedge clk);
        chk("rst_restart_we", 64'(write_en_glb_psum), 64'd1);
        chk("rst_restart_waddr", 64'(w_addr_glb_psum), 64'd500);
        chk("rst_restart_wdata", 64'(w_data_glb_psum), 64'd10);
        wait_done(100);
        chk("rst_restart_last", 64'(glb[508]), 64'd18);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/router_psum.md
Name: router_psum

Overview:
- Write-back router for partial sums: the opposite direction of the weight router's GLB-to-spad load path.
- On a start pulse from the control unit, reads a PE's output psums from its psum spad and writes them into the psum GLB at sequential addresses.
- Each psum is either written directly or accumulated with the value already stored at that GLB location (read-modify-write).
- Sits between the PE psum spad read port and the psum GLB read/write ports of GLB_cluster.

Parameters:
- DATA_BITWIDTH, 16, width of a psum word.
- ADDR_BITWIDTH_GLB, 10, psum GLB address width.
- ADDR_BITWIDTH_SPAD, 9, psum spad address width.
- kernel_size, 3, filter edge length.
- act_size, 5, activation edge length.
- PSUM_SPAD_ADDR, 0, first spad address read.
- PSUM_WRITE_ADDR, 500, first GLB address written.
- Derived: N = (act_size-kernel_size+1)^2 psums per transfer (9 at defaults).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- write_psum_ctrl  in  1  start pulse from control unit.
- accum_en  in  1  1 = accumulate with GLB contents; sampled with start.
- read_req_spad_psum  out  1  spad read request.
- r_addr_spad_psum  out  ADDR_BITWIDTH_SPAD  spad read address.
- r_data_spad_psum  in  DATA_BITWIDTH  spad read data, valid the cycle after the request.
- read_req_glb_psum  out  1  GLB read request (accumulate mode only).
- r_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB read address.
- r_data_glb_psum  in  DATA_BITWIDTH  GLB read data, valid the cycle after the request.
- write_en_glb_psum  out  1  GLB write strobe.
- w_addr_glb_psum  out  ADDR_BITWIDTH_GLB  GLB write address.
- w_data_glb_psum  out  DATA_BITWIDTH  GLB write data.
- busy  out  1  high from the first cycle after start until done.
- done  out  1  one-cycle pulse at end of transfer.

Behaviour:
- Reset (reset=0, async): state=IDLE, idx=0, accum mode register=0, all outputs and data registers=0. Takes effect immediately, including mid-transfer: no further write is issued, and a pending write is dropped.
- All outputs are registered/Moore; none combinationally depend on inputs.
- States: IDLE, RD_SPAD, CAP_SPAD, RD_GLB, ACCUM, WRITE, DONE.
- IDLE: on write_psum_ctrl=1 at a clock edge, latch accum_en, set idx=0, go to RD_SPAD. Call that edge cycle 0.
- RD_SPAD: read_req_spad_psum=1, r_addr_spad_psum=PSUM_SPAD_ADDR+idx.
- CAP_SPAD: register r_data_spad_psum. Next state is RD_GLB if accumulating, else WRITE.
- RD_GLB: read_req_glb_psum=1, r_addr_glb_psum=PSUM_WRITE_ADDR+idx.
- ACCUM: register spad_val + r_data_glb_psum, truncated modulo 2^DATA_BITWIDTH (unsigned wrap, no saturation).
- WRITE: write_en_glb_psum=1, w_addr_glb_psum=PSUM_WRITE_ADDR+idx, w_data_glb_psum=captured or summed value.
  - If idx==N-1, go to DONE; else increment idx and go to RD_SPAD.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- Request/strobe signals are high only in their own state; address/data outputs hold their last value otherwise.
- Timing, non-accumulate mode: element i writes in cycle 3+3i; done in cycle 3N+1 (28 at defaults).
- Timing, accumulate mode: element i writes in cycle 5+5i; done in cycle 5N+1 (46 at defaults).
- Address arithmetic truncates to port width, so addresses wrap past 2^ADDR_BITWIDTH-1 to 0.
- write_psum_ctrl while busy or in DONE is ignored, not queued.
- A start asserted in the cycle after done is accepted.
- accum_en changes mid-transfer have no effect.

Test Plan:
- Direct write: spad[0..8]=10..18, accum_en=0, start pulse → exactly 9 writes, GLB[500..508]=10..18, write_en high in cycles 3,6,…,27, done in cycle 28, busy high cycles 1–27.
- Accumulate: GLB[500..508]=100, spad[0..8]=1..9, accum_en=1 → GLB[500..508]=101..109, GLB read requests in cycles 3,8,…,43, done in cycle 46.
- Overflow: GLB[500]=16'hFFFF, spad[0]=2, accum_en=1 → GLB[500]=16'h0001, no other side effects.
- Start during busy: second pulse in cycle 10 → ignored, still exactly 9 writes; new start in cycle 29 → second full transfer begins, RD_SPAD in cycle 30.
- Reset mid-op: reset=0 during cycle 10 of a direct transfer → all outputs 0 immediately, no further writes, GLB[503..508] unchanged; after release, new start restarts at idx 0 (spad addr 0, GLB addr 500).
- Address wrap: PSUM_WRITE_ADDR=1020 → writes land at GLB addresses 1020,1021,1022,1023,0,1,2,3,4.
